// File: rtl/shift_ring_counter.sv
// shift_ring_counter
//   Bidirectional ring (one-hot, MODE=0) or Johnson (twisted-ring, MODE=1)
//   counter of WIDTH bits with parallel load.
//   - out     : state register, driven straight from the flops.
//   - wrap    : registered pulse, high for the cycle after an enabled shift
//               that has just landed on HOME.
//   - illegal : combinational flag, out is not a reachable state for MODE.
//   Priority on each rising clk edge: load, then en, then hold.
//   Optional build macro SHIFT_RING_COUNTER_SELFCORRECT_EN:
//     defined   -> a shift out of an illegal state, or a load of an illegal
//                  value, lands on HOME instead.
//     undefined -> shifts and loads are applied literally; illegal only
//                  reports the state.
module shift_ring_counter #(
  parameter int WIDTH = 4,  // 2..32
  parameter int MODE  = 0   // 0 = ring, 1 = Johnson
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  // Ring counters start with bit0 set; Johnson counters start at all zeros.
  localparam logic [WIDTH-1:0] HOME = (MODE == 0) ? ONE : ZERO;

  // Ring: exactly one bit set (non-zero power of two).
  // Johnson: a contiguous low run of ones (v+1 is a power of two or wraps
  // to zero) or a contiguous high run of ones (same test on ~v). Both
  // forms cover all-zeros and all-ones, giving 2*WIDTH legal states.
  function automatic logic legal_state(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] v_inv;
    logic             ok;
    v_inv = ~v;
    if (MODE == 0) begin
      ok = (v != ZERO) && ((v & (v - ONE)) == ZERO);
    end else begin
      ok = ((v & (v + ONE)) == ZERO) || ((v_inv & (v_inv + ONE)) == ZERO);
    end
    return ok;
  endfunction

  logic [WIDTH-1:0] r_state;
  logic             r_wrap;

  logic [WIDTH-1:0] w_shift_l;
  logic [WIDTH-1:0] w_shift_r;
  logic [WIDTH-1:0] w_shift_raw;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_load;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap_next;
  logic             w_illegal;

  // Candidate shifted values in both directions; dir picks one every edge,
  // so a reversal takes effect on the very next shift.
  always_comb begin
    w_shift_l = r_state;
    w_shift_r = r_state;
    if (MODE == 0) begin
      w_shift_l = {r_state[WIDTH-2:0], r_state[WIDTH-1]};
      w_shift_r = {r_state[0], r_state[WIDTH-1:1]};
    end else begin
      w_shift_l = {r_state[WIDTH-2:0], ~r_state[WIDTH-1]};
      w_shift_r = {~r_state[0], r_state[WIDTH-1:1]};
    end
    if (dir) begin
      w_shift_raw = w_shift_r;
    end else begin
      w_shift_raw = w_shift_l;
    end
  end

  // Legality of the current state, no latency.
  always_comb begin
    w_illegal = ~legal_state(r_state);
  end

`ifdef SHIFT_RING_COUNTER_SELFCORRECT_EN
  // Recovery: anything that would enter or stay in an illegal state is
  // redirected to HOME.
  always_comb begin
    if (w_illegal) begin
      w_shift = HOME;
    end else begin
      w_shift = w_shift_raw;
    end
    if (legal_state(load_val)) begin
      w_load = load_val;
    end else begin
      w_load = HOME;
    end
  end
`else
  // No recovery: shift and load values are used exactly as computed.
  always_comb begin
    w_shift = w_shift_raw;
    w_load  = load_val;
  end
`endif

  // Next state and wrap pulse: load beats en beats hold. Only an enabled
  // shift can raise wrap, so loading HOME never pulses it.
  always_comb begin
    w_next      = r_state;
    w_wrap_next = 1'b0;
    if (load) begin
      w_next      = w_load;
      w_wrap_next = 1'b0;
    end else if (en) begin
      w_next      = w_shift;
      w_wrap_next = (w_shift == HOME);
    end else begin
      w_next      = r_state;
      w_wrap_next = 1'b0;
    end
  end

  // State and wrap registers; reset forces HOME immediately, clk-independent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HOME;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wrap  <= w_wrap_next;
    end
  end

  assign out     = r_state;
  assign wrap    = r_wrap;
  assign illegal = w_illegal;

endmodule

// File: tb/tb_shift_ring_counter.sv
// Directed self-checking bench for shift_ring_counter. Six instances
// (WIDTH 4/2/32 x MODE 0/1) share clock and controls; expectations come from
// hand-written vectors (WIDTH=4) and closed-form position formulas.
module tb_shift_ring_counter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        dir;
  logic        load;
  logic [3:0]  lv4;
  logic [1:0]  lv2;
  logic [31:0] lv32;

  logic [3:0]  o40, o41;
  logic [1:0]  o20, o21;
  logic [31:0] o320, o321;
  logic        w40, w41, w20, w21, w320, w321;
  logic        i40, i41, i20, i21, i320, i321;

  int checks = 0;
  int errors = 0;

  shift_ring_counter #(.WIDTH(4), .MODE(0)) d40 (.clk(clk), .rst(rst), .en(en), .dir(dir),
    .load(load), .load_val(lv4), .out(o40), .wrap(w40), .illegal(i40));
  shift_ring_counter #(.WIDTH(4), .MODE(1)) d41 (.clk(clk), .rst(rst), .en(en), .dir(dir),
    .load(load), .load_val(lv4), .out(o41), .wrap(w41), .illegal(i41));
  shift_ring_counter #(.WIDTH(2), .MODE(0)) d20 (.clk(clk), .rst(rst), .en(en), .dir(dir),
    .load(load), .load_val(lv2), .out(o20), .wrap(w20), .illegal(i20));
  shift_ring_counter #(.WIDTH(2), .MODE(1)) d21 (.clk(clk), .rst(rst), .en(en), .dir(dir),
    .load(load), .load_val(lv2), .out(o21), .wrap(w21), .illegal(i21));
  shift_ring_counter #(.WIDTH(32), .MODE(0)) d320 (.clk(clk), .rst(rst), .en(en), .dir(dir),
    .load(load), .load_val(lv32), .out(o320), .wrap(w320), .illegal(i320));
  shift_ring_counter #(.WIDTH(32), .MODE(1)) d321 (.clk(clk), .rst(rst), .en(en), .dir(dir),
    .load(load), .load_val(lv32), .out(o321), .wrap(w321), .illegal(i321));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=4 vectors after each shift from reset.
  logic [3:0] e40l [0:7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] e40r [0:7] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [3:0] e41l [0:7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [3:0] e41r [0:7] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle to the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Async reset pulse placed between edges.
  task automatic pulse_reset();
    rst  = 1'b1;
    en   = 1'b0;
    load = 1'b0;
    #2;
    rst  = 1'b0;
  endtask

  // Ring position after k shifts from HOME.
  function automatic logic [63:0] ring_exp(input int w, input int k, input logic d);
    int m;
    int sh;
    m  = k % w;
    sh = d ? ((w - m) % w) : m;
    return 64'd1 << sh;
  endfunction

  // Johnson position after k shifts from all-zeros.
  function automatic logic [63:0] john_exp(input int w, input int k, input logic d);
    int          m;
    logic [63:0] mask;
    m    = k % (2 * w);
    mask = (64'd1 << w) - 64'd1;
    if (!d) begin
      if (m <= w) return (64'd1 << m) - 64'd1;
      else        return mask & ~((64'd1 << (m - w)) - 64'd1);
    end else begin
      if (m <= w) return mask & ~((64'd1 << (w - m)) - 64'd1);
      else        return (64'd1 << (2 * w - m)) - 64'd1;
    end
  endfunction

  // Full-period sweep in one direction checking every instance each shift.
  task automatic sweep(input logic d);
    dir = d;
    en  = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      step();
      chk("w32m0_out", o320, ring_exp(32, k, d));
      chk("w32m0_wrap", w320, (k % 32) == 0);
      chk("w32m0_ill", i320, 0);
      chk("w32m1_out", o321, john_exp(32, k, d));
      chk("w32m1_wrap", w321, (k % 64) == 0);
      chk("w32m1_ill", i321, 0);
      chk("w2m0_out", o20, ring_exp(2, k, d));
      chk("w2m0_wrap", w20, (k % 2) == 0);
      chk("w2m0_ill", i20, 0);
      chk("w2m1_out", o21, john_exp(2, k, d));
      chk("w2m1_wrap", w21, (k % 4) == 0);
      chk("w2m1_ill", i21, 0);
      if (k <= 8) begin
        chk("w4m0_out", o40, d ? e40r[k-1] : e40l[k-1]);
        chk("w4m0_wrap", w40, (k % 4) == 0);
        chk("w4m0_ill", i40, 0);
        chk("w4m1_out", o41, d ? e41r[k-1] : e41l[k-1]);
        chk("w4m1_wrap", w41, k == 8);
        chk("w4m1_ill", i41, 0);
      end
    end
    en = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    dir  = 1'b0;
    load = 1'b0;
    lv4  = 4'b0000;
    lv2  = 2'b01;
    lv32 = 32'h0000_0001;

    // Reset state before any clock edge.
    #2;
    chk("rst_w4m0_out", o40, 4'b0001);
    chk("rst_w4m1_out", o41, 4'b0000);
    chk("rst_w4m0_wrap", w40, 1'b0);
    chk("rst_w4m0_ill", i40, 1'b0);
    chk("rst_w4m1_ill", i41, 1'b0);
    chk("rst_w32m0_out", o320, 32'h0000_0001);

    // Left sweep; first shift on first edge after rst release.
    @(negedge clk);
    rst = 1'b0;
    sweep(1'b0);

    // Right sweep from HOME.
    @(negedge clk);
    pulse_reset();
    @(negedge clk);
    sweep(1'b1);

    // Direction reversal and hold.
    pulse_reset();
    @(negedge clk);
    en = 1'b1; dir = 1'b0;
    step(); step();
    chk("rev_pre", o40, 4'b0100);
    step();
    chk("rev_l", o40, 4'b1000);
    dir = 1'b1;
    step();
    chk("rev_r1", o40, 4'b0100);
    step();
    chk("rev_r2", o40, 4'b0010);
    en = 1'b0;
    for (int h = 0; h < 3; h++) begin
      step();
      chk("hold_out", o40, 4'b0010);
      chk("hold_wrap", w40, 1'b0);
    end

    // Loads: legal value ignores en/dir, HOME load gives no wrap.
    load = 1'b1; en = 1'b1; dir = 1'b1; lv4 = 4'b1000;
    step();
    chk("ld_legal_out", o40, 4'b1000);
    chk("ld_legal_wrap", w40, 1'b0);
    lv4 = 4'b0001;
    step();
    chk("ld_home_out", o40, 4'b0001);
    chk("ld_home_wrap", w40, 1'b0);

    // Illegal load then shift left.
    lv4 = 4'b0110; dir = 1'b0;
    step();
    load = 1'b0;
`ifdef SHIFT_RING_COUNTER_SELFCORRECT_EN
    chk("ld_bad_w4m0_out", o40, 4'b0001);
    chk("ld_bad_w4m0_ill", i40, 1'b0);
    chk("ld_bad_w4m1_out", o41, 4'b0000);
    chk("ld_bad_w4m1_ill", i41, 1'b0);
    step();
    chk("sh_bad_out", o40, 4'b0010);
    chk("sh_bad_ill", i40, 1'b0);
`else
    chk("ld_bad_w4m0_out", o40, 4'b0110);
    chk("ld_bad_w4m0_ill", i40, 1'b1);
    chk("ld_bad_w4m1_out", o41, 4'b0110);
    chk("ld_bad_w4m1_ill", i41, 1'b1);
    chk("ld_bad_wrap", w40, 1'b0);
    step();
    chk("sh_bad_out", o40, 4'b1100);
    chk("sh_bad_ill", i40, 1'b1);
    chk("sh_bad_wrap", w40, 1'b0);
`endif
    en = 1'b0;

    // Async reset clears a live wrap pulse between edges.
    pulse_reset();
    @(negedge clk);
    en = 1'b1; dir = 1'b0;
    for (int s = 0; s < 4; s++) step();
    chk("pre_rst_wrap", w40, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_w4m0_out", o40, 4'b0001);
    chk("async_w4m0_wrap", w40, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-Johnson-sequence at 1110.
    for (int s = 0; s < 5; s++) step();
    chk("pre_rst_w4m1", o41, 4'b1110);
    #2 rst = 1'b1;
    #1;
    chk("async_w4m1_out", o41, 4'b0000);
    chk("async_w4m1_wrap", w41, 1'b0);
    chk("async_w4m1_ill", i41, 1'b0);

    // rst, load and en all high on one edge: reset wins.
    load = 1'b1; en = 1'b1; lv4 = 4'b0100;
    step();
    chk("rst_win_w4m0", o40, 4'b0001);
    chk("rst_win_w4m1", o41, 4'b0000);
    chk("rst_win_wrap", w41, 1'b0);

    // First edge after release shifts.
    rst = 1'b0; load = 1'b0; en = 1'b1; dir = 1'b0;
    step();
    chk("first_w4m0", o40, 4'b0010);
    chk("first_w4m1", o41, 4'b0001);
    en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
